// File: rtl/motor_drive.sv
// Dual H-bridge driver: turns registered steering commands into per-wheel direction
// pins and PWM enables, with duty ramping, differential turning and reversal dead-time.
module motor_drive #(
  parameter int unsigned PWM_PERIOD   = 1000,
  parameter int unsigned DUTY_FULL    = 800,
  parameter int unsigned DUTY_TURN    = 300,
  parameter int unsigned RAMP_STEP    = 20,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic clk,
  input  logic start,
  input  logic forward,
  input  logic back,
  input  logic turn_left,
  input  logic turn_right,
  output logic l_in1,
  output logic l_in2,
  output logic r_in1,
  output logic r_in2,
  output logic pwm_l,
  output logic pwm_r,
  output logic moving
);

  localparam int unsigned W  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  localparam logic [W-1:0]  CNT_LAST  = W'(PWM_PERIOD - 1);
  localparam logic [W-1:0]  FULL      = W'(DUTY_FULL);
  localparam logic [W-1:0]  TURN      = W'(DUTY_TURN);
  localparam logic [W:0]    STEP_X    = (W + 1)'(RAMP_STEP);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PERIODS);
  localparam logic [DW-1:0] DEAD_ONE  = DW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DEAD} state_e;
  typedef enum logic [1:0] {CMD_STOP, CMD_FWD, CMD_REV} cmd_e;

  logic         fwd_q, back_q, tl_q, tr_q;
  cmd_e         cmd;
  state_e       state;
  cmd_e         dir;
  logic [DW-1:0] dead_cnt;
  logic [1:0]   pins;
  logic [W-1:0] cnt;
  logic         wrap;
  logic [W-1:0] duty_l, duty_r;
  logic [W-1:0] tgt_l, tgt_r;
  logic         duties_zero;

  function automatic logic [1:0] pins_of(input cmd_e c);
    case (c)
      CMD_FWD: pins_of = 2'b10;
      CMD_REV: pins_of = 2'b01;
      default: pins_of = 2'b00;
    endcase
  endfunction

  // Step toward tgt by at most RAMP_STEP; one extra bit keeps the sums from wrapping.
  function automatic logic [W-1:0] ramp(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0] cur_x;
    logic [W:0] tgt_x;
    logic [W:0] up;
    logic [W:0] lim;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    up    = cur_x + STEP_X;
    lim   = tgt_x + STEP_X;
    ramp  = cur;
    if (cur_x < tgt_x) begin
      ramp = (up > tgt_x) ? tgt : up[W-1:0];
    end else if (cur_x > tgt_x) begin
      ramp = (cur_x < lim) ? tgt : W'(cur_x - STEP_X);
    end
  endfunction

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      fwd_q  <= 1'b0;
      back_q <= 1'b0;
      tl_q   <= 1'b0;
      tr_q   <= 1'b0;
    end else begin
      fwd_q  <= forward;
      back_q <= back;
      tl_q   <= turn_left;
      tr_q   <= turn_right;
    end
  end

  always_comb begin
    cmd = CMD_STOP;
    if (fwd_q && !back_q)      cmd = CMD_FWD;
    else if (back_q && !fwd_q) cmd = CMD_REV;
  end

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge start) begin
    if (!start)    cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Targets are only live while running in the commanded direction; a pending reversal
  // or stop already ramps toward zero on the wrap where it is first seen.
  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    if (state == RUN && cmd == dir) begin
      tgt_l = FULL;
      tgt_r = FULL;
      if (tl_q && !tr_q)      tgt_l = TURN;
      else if (tr_q && !tl_q) tgt_r = TURN;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      duty_l <= '0;
      duty_r <= '0;
    end else if (wrap) begin
      duty_l <= ramp(duty_l, tgt_l);
      duty_r <= ramp(duty_r, tgt_r);
    end
  end

  assign duties_zero = (duty_l == '0) && (duty_r == '0);

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      pwm_l <= 1'b0;
      pwm_r <= 1'b0;
    end else begin
      pwm_l <= (cnt < duty_l);
      pwm_r <= (cnt < duty_r);
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state    <= IDLE;
      dir      <= CMD_FWD;
      dead_cnt <= '0;
      pins     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          pins <= 2'b00;
          if (cmd != CMD_STOP) begin
            state <= RUN;
            dir   <= cmd;
            pins  <= pins_of(cmd);
          end
        end
        RUN: begin
          pins <= pins_of(dir);
          if (wrap) begin
            if (cmd != CMD_STOP && cmd != dir) begin
              state <= DRAIN;
            end else if (cmd == CMD_STOP && duties_zero) begin
              state <= IDLE;
              pins  <= 2'b00;
            end
          end
        end
        DRAIN: begin
          pins <= pins_of(dir);
          if (wrap && duties_zero) begin
            state    <= DEAD;
            dead_cnt <= DEAD_INIT;
            pins     <= 2'b00;
          end
        end
        DEAD: begin
          pins <= 2'b00;
          if (wrap) begin
            if (dead_cnt <= DEAD_ONE) begin
              dead_cnt <= '0;
              if (cmd != CMD_STOP) begin
                state <= RUN;
                dir   <= cmd;
                pins  <= pins_of(cmd);
              end else begin
                state <= IDLE;
              end
            end else begin
              dead_cnt <= dead_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          pins  <= 2'b00;
        end
      endcase
    end
  end

  assign l_in1  = pins[1];
  assign l_in2  = pins[0];
  assign r_in1  = pins[1];
  assign r_in2  = pins[0];
  assign moving = (duty_l != '0) || (duty_r != '0);

endmodule
